refill_arbiter: RTL and testbench
=================================

REFILL_ARBITER -- requirements
Module: refill_arbiter

Interface
REQ-001 Parameter OFFSET_LEN, default 5, log2 of line bytes; the line holds WORDS = 2^(OFFSET_LEN-2) 32-bit words.
REQ-002 Parameter AXI_ID, default 4'd0, constant ARID value driven on every read burst.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  ICache line-refill request, level, held until i_gnt.
REQ-006 i_addr  input  32  ICache miss address; low OFFSET_LEN bits ignored.
REQ-007 i_gnt  output  1  one-cycle pulse; line_data valid for ICache.
REQ-008 d_req / d_addr / d_gnt  same widths and semantics as i_*, for DCache.
REQ-009 line_data  output  WORDS x 32  assembled refill line, shared by both requesters.
REQ-010 refill_err  output  1  valid with the gnt pulse; 1 if any beat had RRESP != 2'b00.
REQ-011 arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 are outputs; arready 1 is an input (AXI4 AR channel).
REQ-012 rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 are inputs; rready 1 is an output (AXI4 R channel).

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ADDR, DATA, DONE.
REQ-014 IDLE: if i_req or d_req is high, latch the winner and {addr[31:OFFSET_LEN], OFFSET_LEN'b0}, clear the beat counter and error flag, then go to ADDR.
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; after reset DCache has priority.
REQ-016 ADDR: arvalid=1, araddr=latched aligned address, arlen=WORDS-1, arsize=3'b010, arburst=2'b01 (INCR), arid=AXI_ID; AR fields stable until arready.
REQ-017 ADDR -> DATA on the cycle arvalid && arready; arvalid is low in all other states.
REQ-018 DATA: rready=1; each cycle with rvalid && rready writes rdata to line_data[cnt], increments cnt, ORs (rresp != 0) into the error flag.
REQ-019 DATA -> DONE on an accepted beat with rlast=1 or cnt==WORDS-1, whichever comes first.
REQ-020 Beats beyond WORDS are impossible after DONE because rready=0; an early rlast ends the burst and leaves unwritten words at their previous values.
REQ-021 DONE: assert exactly the winner's gnt for one cycle with refill_err; line_data is stable in that cycle; the next state is IDLE.
REQ-022 Minimum latency from req sampled in IDLE to gnt SHALL be WORDS+3 cycles with arready and rvalid held high: 1 IDLE, 1 ADDR, WORDS DATA, 1 DONE.
REQ-023 A requester SHALL drop req in the cycle after its gnt. The arbiter samples req only in IDLE, so a req still high in the DONE cycle does not cause a double grant.
REQ-024 If the winning req drops mid-transaction, the burst still completes and gnt still pulses.
REQ-025 The latched address and winner SHALL NOT change between IDLE and the return to IDLE, regardless of i_addr or d_addr changes.
REQ-026 rid is ignored; only one burst is outstanding at a time.

Reset
REQ-027 rst=1 at a clock edge: state=IDLE; arvalid, rready, i_gnt, d_gnt and refill_err=0; cnt=0; round-robin pointer selects DCache. line_data contents are don't-care.
REQ-028 Reset mid-ADDR or mid-DATA SHALL abandon the burst without issuing a gnt. Recovery of the interconnect is the system's responsibility.

Verification
REQ-029 Only i_req, i_addr=0x1FC0_0024, arready=1, 8 beats 0x11..0x88 with rlast on beat 8: araddr=0x1FC0_0020, arlen=7, i_gnt on cycle 11, line_data[0..7]=0x11..0x88, refill_err=0.
REQ-030 i_req and d_req rise together after reset: DCache is served first. If both are raised again after their grants, ICache is served next.
REQ-031 arready held low for 5 cycles: arvalid and araddr stay stable for the whole wait, and exactly one AR handshake occurs.
REQ-032 rvalid gaps of 2 cycles between beats, and rresp=2'b10 on beat 3: all 8 words are captured in order and refill_err=1 with the gnt.
REQ-033 rst pulsed during beat 4 of DATA: next cycle is IDLE with all outputs 0 and no gnt pulse. A fresh request afterwards completes normally.
REQ-034 rlast on beat 6: DONE follows, gnt pulses, and words 6..7 hold their previous values.

Source files
------------

// File: rtl/refill_arbiter.sv
// Round-robin refill arbiter: ICache and DCache line refills share one AXI4 read port.
// One burst in flight; the assembled line is presented with a one-cycle grant pulse.
module refill_arbiter #(
    parameter int         OFFSET_LEN = 5,
    parameter logic [3:0] AXI_ID     = 4'd0,
    localparam int        WORDS      = 2 ** (OFFSET_LEN - 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req,
    input  logic [31:0]            i_addr,
    output logic                   i_gnt,
    input  logic                   d_req,
    input  logic [31:0]            d_addr,
    output logic                   d_gnt,
    output logic [WORDS-1:0][31:0] line_data,
    output logic                   refill_err,
    output logic [3:0]             arid,
    output logic [31:0]            araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [3:0]             rid,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready
);

    localparam int CNT_W = (OFFSET_LEN > 2) ? (OFFSET_LEN - 2) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic             winner_d_r;
    logic             prio_d_r;
    logic [31:0]      addr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;
    logic             pick_d_s;
    logic [31:0]      req_addr_s;
    logic             beat_err_s;
    logic             last_beat_s;
    logic             unused_s;

    assign arid    = AXI_ID;
    assign araddr  = addr_r;
    assign arlen   = 8'(WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign unused_s = ^{rid, i_addr[OFFSET_LEN-1:0], d_addr[OFFSET_LEN-1:0]};

    // Arbitration pick and per-beat status decode
    always_comb begin
        pick_d_s    = 1'b0;
        req_addr_s  = 32'd0;
        beat_err_s  = (rresp != 2'b00);
        last_beat_s = rlast || (cnt_r == CNT_W'(WORDS - 1));
        if (d_req && (!i_req || prio_d_r)) begin
            pick_d_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
        end
        if (pick_d_s) begin
            req_addr_s = {d_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
        end else begin
            req_addr_s = {i_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
        end
    end

    // Refill FSM with registered AXI handshakes, grants and line capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            i_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            refill_err <= 1'b0;
            cnt_r      <= '0;
            err_r      <= 1'b0;
            prio_d_r   <= 1'b1;
            winner_d_r <= 1'b0;
            addr_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    i_gnt      <= 1'b0;
                    d_gnt      <= 1'b0;
                    refill_err <= 1'b0;
                    if (i_req || d_req) begin
                        winner_d_r <= pick_d_s;
                        prio_d_r   <= !pick_d_s;
                        addr_r     <= req_addr_s;
                        cnt_r      <= '0;
                        err_r      <= 1'b0;
                        arvalid    <= 1'b1;
                        state_r    <= ADDR;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        line_data[cnt_r] <= rdata;
                        cnt_r            <= cnt_r + CNT_W'(1);
                        err_r            <= err_r | beat_err_s;
                        // An early rlast ends the burst; untouched words keep old data
                        if (last_beat_s) begin
                            rready     <= 1'b0;
                            i_gnt      <= !winner_d_r;
                            d_gnt      <= winner_d_r;
                            refill_err <= err_r | beat_err_s;
                            state_r    <= DONE;
                        end
                    end
                end
                DONE: begin
                    i_gnt      <= 1'b0;
                    d_gnt      <= 1'b0;
                    refill_err <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed bench for refill_arbiter: the bench plays the AXI slave and checks
// grants, AR fields, assembled lines, error flag and arbitration order.
module tb_refill_arbiter;

    localparam int WORDS = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_req, d_req;
    logic [31:0]            i_addr, d_addr;
    logic                   i_gnt, d_gnt;
    logic [WORDS-1:0][31:0] line_data;
    logic                   refill_err;
    logic [3:0]             arid;
    logic [31:0]            araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   arvalid, arready;
    logic [3:0]             rid;
    logic [31:0]            rdata;
    logic [1:0]             rresp;
    logic                   rlast, rvalid, rready;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_cnt  = 0;

    refill_arbiter #(.OFFSET_LEN(5), .AXI_ID(4'd5)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .line_data(line_data), .refill_err(refill_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (arvalid && arready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        check_eq({tag, "_rready"}, 32'(rready), 32'd0);
        check_eq({tag, "_gnt"}, {30'd0, i_gnt, d_gnt}, 32'd0);
        check_eq({tag, "_err"}, 32'(refill_err), 32'd0);
    endtask

    // Acts as the AXI slave for one burst, called at a negedge once the request is driven.
    task automatic serve(input int ar_wait, input int gap, input int err_beat,
                         input int last_beat, input int rst_beat,
                         input logic [31:0] base, input logic [31:0] exp_addr,
                         input logic exp_d, output logic got_err);
        int t;
        int hs0;
        got_err = 1'b0;
        hs0 = hs_cnt;
        t = 0;
        while (!arvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("ar_seen", 32'(arvalid), 32'd1);
        check_eq("araddr", araddr, exp_addr);
        check_eq("arlen", 32'(arlen), 32'd7);
        check_eq("arsize_burst_id", {21'd0, arsize, arburst, 2'd0, arid}, {21'd0, 3'b010, 2'b01, 2'd0, 4'd5});
        for (int w = 0; w < ar_wait; w++) begin
            i_addr = 32'hDEAD_BEEF;
            d_addr = 32'h1234_5678;
            @(negedge clk);
            check_eq("ar_hold_valid", 32'(arvalid), 32'd1);
            check_eq("ar_hold_addr", araddr, exp_addr);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check_eq("rready_up", 32'(rready), 32'd1);
        check_eq("arvalid_down", 32'(arvalid), 32'd0);
        for (int b = 1; b <= last_beat; b++) begin
            for (int g = 0; g < gap; g++) begin
                rvalid = 1'b0;
                @(negedge clk);
            end
            rvalid = 1'b1;
            rdata  = base * 32'(b);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == last_beat);
            if (b == rst_beat) rst = 1'b1;
            @(negedge clk);
            if (b == rst_beat) begin
                rst = 1'b0;
                rvalid = 1'b0;
                rlast = 1'b0;
                i_req = 1'b0;
                d_req = 1'b0;
                check_idle_outputs("mid_rst");
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check_idle_outputs("post_rst");
                end
                return;
            end
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        check_eq("gnt_pair", {30'd0, i_gnt, d_gnt}, {30'd0, !exp_d, exp_d});
        check_eq("ar_handshakes", 32'(hs_cnt - hs0), 32'd1);
        got_err = refill_err;
    endtask

    task automatic check_line(input string tag, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++)
            check_eq(tag, line_data[k], base * 32'(k + 1));
    endtask

    logic        err;
    int          c0;

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = 32'd0; d_addr = 32'd0;
        arready = 1'b0; rid = 4'd3; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic ICache refill with latency check
        i_addr = 32'h1FC0_0024;
        i_req  = 1'b1;
        c0     = cyc;
        serve(0, 0, 0, 8, 0, 32'h11, 32'h1FC0_0020, 1'b0, err);
        check_eq("latency", 32'(cyc - c0), 32'd10);
        check_eq("err_clean", 32'(err), 32'd0);
        check_line("line_basic", 32'h11, 8);
        @(negedge clk);
        check_eq("gnt_one_cycle", {30'd0, i_gnt, d_gnt}, 32'd0);
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("no_double_grant", 32'(arvalid), 32'd0);

        // Round robin after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_addr = 32'h0000_1100; d_addr = 32'h0000_2200;
        i_req = 1'b1; d_req = 1'b1;
        serve(0, 0, 0, 8, 0, 32'h3, 32'h0000_2200, 1'b1, err);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1;
        serve(0, 0, 0, 8, 0, 32'h5, 32'h0000_1100, 1'b0, err);
        @(negedge clk);
        i_req = 1'b0;
        serve(0, 0, 0, 8, 0, 32'h7, 32'h0000_2200, 1'b1, err);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);

        // AR backpressure with addresses changing underneath
        d_addr = 32'h8000_104C;
        d_req  = 1'b1;
        serve(5, 0, 0, 8, 0, 32'h0101_0101, 32'h8000_1040, 1'b1, err);
        check_line("line_arwait", 32'h0101_0101, 8);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);

        // R gaps plus a SLVERR on beat 3
        i_addr = 32'h0000_4000;
        i_req  = 1'b1;
        serve(0, 2, 3, 8, 0, 32'h1000_0001, 32'h0000_4000, 1'b0, err);
        check_eq("err_slverr", 32'(err), 32'd1);
        check_line("line_gaps", 32'h1000_0001, 8);
        @(negedge clk);
        i_req = 1'b0;
        check_eq("err_clears", 32'(refill_err), 32'd0);
        @(negedge clk);

        // Early rlast on beat 6
        i_addr = 32'h0000_5000;
        i_req  = 1'b1;
        serve(0, 0, 0, 6, 0, 32'h2000_0003, 32'h0000_5000, 1'b0, err);
        check_eq("err_early", 32'(err), 32'd0);
        check_line("line_early", 32'h2000_0003, 6);
        check_eq("word6_kept", line_data[6], 32'h1000_0001 * 32'd7);
        check_eq("word7_kept", line_data[7], 32'h1000_0001 * 32'd8);
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);

        // Reset during beat 4, then a fresh request
        i_addr = 32'h0000_6000;
        i_req  = 1'b1;
        serve(0, 0, 0, 8, 4, 32'h9, 32'h0000_6000, 1'b0, err);
        d_addr = 32'h0000_7000;
        d_req  = 1'b1;
        serve(0, 0, 0, 8, 0, 32'h0300_0007, 32'h0000_7000, 1'b1, err);
        check_eq("err_after_rst", 32'(err), 32'd0);
        check_line("line_after_rst", 32'h0300_0007, 8);
        @(negedge clk);
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
